// File: rtl/e203_subsys_pllclkdiv_pkg.sv
// Shared widths, reset defaults and FSM encoding for the PLL clock divider
// configuration sequencer.
package e203_subsys_pllclkdiv_pkg;

    localparam int DIV_W    = 6;
    localparam int SETTLE_W = 8;

    localparam logic [DIV_W-1:0] RST_DIV_DEF = 6'd0;

    localparam logic [2:0] ST_IDLE_C    = 3'd0;
    localparam logic [2:0] ST_QUIESCE_C = 3'd1;
    localparam logic [2:0] ST_UPDATE_C  = 3'd2;
    localparam logic [2:0] ST_SETTLE_C  = 3'd3;
    localparam logic [2:0] ST_RELEASE_C = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_C,
        ST_QUIESCE = ST_QUIESCE_C,
        ST_UPDATE  = ST_UPDATE_C,
        ST_SETTLE  = ST_SETTLE_C,
        ST_RELEASE = ST_RELEASE_C
    } state_e;

    // One full divided period is 2*(div+1) input clocks; bypass needs none.
    function automatic logic [SETTLE_W-1:0] settle_raw(
        input logic             divby1,
        input logic [DIV_W-1:0] div
    );
        logic [SETTLE_W-1:0] ext;
        ext = {{(SETTLE_W-DIV_W){1'b0}}, div} + SETTLE_W'(1);
        return divby1 ? '0 : (ext << 1);
    endfunction

endpackage

// File: rtl/e203_subsys_pllclkdiv_settle_cnt.sv
// Loadable down-counter with optional minimum clamp on load and a
// terminal flag raised while the count is 1.
module e203_subsys_pllclkdiv_settle_cnt #(
    parameter int unsigned    W       = 8,
    parameter bit             USE_MIN = 1'b1,
    parameter logic [W-1:0]   MIN_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] load_sel;

    generate
        if (USE_MIN) begin : g_min
            assign load_sel = (load_val_i < MIN_VAL) ? MIN_VAL : load_val_i;
        end else begin : g_raw
            assign load_sel = load_val_i;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_sel;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/e203_subsys_pllclkdiv_ctrl.sv
// Divider config sequencer: freeze consumer, apply new divby1/div, wait one
// divided period, release. Runs entirely on the undivided PLL clock.
module e203_subsys_pllclkdiv_ctrl
    import e203_subsys_pllclkdiv_pkg::*;
#(
    parameter int unsigned      QUIESCE_TO = 16,
    parameter int unsigned      SETTLE_MIN = 4,
    parameter logic             RST_DIVBY1 = 1'b1,
    parameter logic [DIV_W-1:0] RST_DIV    = RST_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_divby1,
    input  logic [DIV_W-1:0] req_div,
    output logic             hold,
    input  logic             hold_ack,
    output logic             divby1,
    output logic [DIV_W-1:0] div,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned TO_W = $clog2(QUIESCE_TO + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(QUIESCE_TO - 1);
    localparam logic [SETTLE_W-1:0] SMIN = SETTLE_W'(SETTLE_MIN);

    state_e           state_q, state_d;
    logic             sh_divby1_q;
    logic [DIV_W-1:0] sh_div_q;
    logic             divby1_q;
    logic [DIV_W-1:0] div_q;
    logic             hold_q, busy_q, done_q, err_q;

    logic accept;
    logic sh_en, upd, err_d;
    logic to_load, to_dec, to_last;
    logic st_load, st_dec, st_last;
    logic active_d;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Timeout counts down from QUIESCE_TO-1 so both counters share one shape.
    e203_subsys_pllclkdiv_settle_cnt #(
        .W       (TO_W),
        .USE_MIN (1'b0),
        .MIN_VAL ('0)
    ) u_to_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (to_load),
        .load_val_i (TO_LOAD),
        .dec_i      (to_dec),
        .last_o     (to_last)
    );

    e203_subsys_pllclkdiv_settle_cnt #(
        .W       (SETTLE_W),
        .USE_MIN (1'b1),
        .MIN_VAL (SMIN)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (st_load),
        .load_val_i (settle_raw(sh_divby1_q, sh_div_q)),
        .dec_i      (st_dec),
        .last_o     (st_last)
    );

    always_comb begin
        state_d = state_q;
        sh_en   = 1'b0;
        upd     = 1'b0;
        err_d   = 1'b0;
        to_load = 1'b0;
        to_dec  = 1'b0;
        st_load = 1'b0;
        st_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_en   = 1'b1;
                    to_load = 1'b1;
                    state_d = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                if (hold_ack) begin
                    state_d = ST_UPDATE;
                end else if (to_last) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_dec = 1'b1;
                end
            end
            ST_UPDATE: begin
                upd     = 1'b1;
                st_load = 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (st_last) begin
                    state_d = ST_RELEASE;
                end else begin
                    st_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign active_d = (state_d == ST_QUIESCE) ||
                      (state_d == ST_UPDATE)  ||
                      (state_d == ST_SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sh_divby1_q <= RST_DIVBY1;
            sh_div_q    <= RST_DIV;
            divby1_q    <= RST_DIVBY1;
            div_q       <= RST_DIV;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= active_d;
            busy_q  <= active_d;
            done_q  <= (state_d == ST_RELEASE);
            err_q   <= err_d;
            if (sh_en) begin
                sh_divby1_q <= req_divby1;
                sh_div_q    <= req_div;
            end
            if (upd) begin
                divby1_q <= sh_divby1_q;
                div_q    <= sh_div_q;
            end
        end
    end

    assign hold   = hold_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign divby1 = divby1_q;
    assign div    = div_q;

endmodule

// File: tb/tb_e203_subsys_pllclkdiv_ctrl.sv
// Directed bench for the divider config sequencer with an expectation
// queue filled at request time and drained on done/err.
module tb_e203_subsys_pllclkdiv_ctrl;

    localparam int QTO  = 16;
    localparam int SMIN = 4;
    localparam int MAXW = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_divby1;
    logic [5:0] req_div;
    logic       hold;
    logic       hold_ack;
    logic       divby1;
    logic [5:0] div;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    int   ack_mode = 0;
    logic hd1, hd2;

    bit       cur_d1 = 1'b1;
    bit [5:0] cur_d  = 6'd0;

    typedef struct {
        bit       is_err;
        int       lat;
        bit       dv1;
        bit [5:0] dv;
    } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hd1 <= hold;
        hd2 <= hd1;
    end

    always_comb begin
        hold_ack = 1'b0;
        if (ack_mode == 1) hold_ack = hold;
        else if (ack_mode == 2) hold_ack = hd2;
    end

    e203_subsys_pllclkdiv_ctrl #(
        .QUIESCE_TO (QTO),
        .SETTLE_MIN (SMIN),
        .RST_DIVBY1 (1'b1),
        .RST_DIV    (6'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_divby1 (req_divby1),
        .req_div    (req_div),
        .hold       (hold),
        .hold_ack   (hold_ack),
        .divby1     (divby1),
        .div        (div),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_settle(input bit d1, input int d);
        int s;
        s = d1 ? SMIN : 2 * (d + 1);
        if (s < SMIN) s = SMIN;
        return s;
    endfunction

    function automatic exp_t model_req(input bit d1, input bit [5:0] d,
                                       input int mode);
        exp_t e;
        if (mode == 0) begin
            e.is_err = 1'b1;
            e.lat    = QTO;
            e.dv1    = cur_d1;
            e.dv     = cur_d;
        end else begin
            e.is_err = 1'b0;
            e.lat    = exp_settle(d1, int'(d)) + 3 + ((mode == 2) ? 2 : 0);
            e.dv1    = d1;
            e.dv     = d;
            cur_d1   = d1;
            cur_d    = d;
        end
        return e;
    endfunction

    // Entered on a negedge; acceptance happens at the next posedge.
    task automatic wait_result(input bit keep, input bit nd1,
                               input bit [5:0] nd);
        int   n;
        int   rdy_hits;
        exp_t e;
        n        = 0;
        rdy_hits = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("hold_rise", int'(hold), 1);
                chk("busy_rise", int'(busy), 1);
                if (keep) begin
                    req_divby1 = nd1;
                    req_div    = nd;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (done || err || n > MAXW) break;
            if (req_ready) rdy_hits++;
        end
        chk("wait_bound", int'(n <= MAXW), 1);
        chk("ready_low_busy", rdy_hits, 0);
        chk("q_nonempty", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("kind_err", int'(err), int'(e.is_err));
            chk("kind_done", int'(done), int'(!e.is_err));
            chk("latency", n, e.lat);
            chk("divby1_out", int'(divby1), int'(e.dv1));
            chk("div_out", int'(div), int'(e.dv));
            chk("hold_off", int'(hold), 0);
            chk("busy_off", int'(busy), 0);
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("err_pulse", int'(err), 0);
        chk("ready_back", int'(req_ready), 1);
    endtask

    task automatic do_req(input bit d1, input bit [5:0] d, input int mode,
                          input bit keep, input bit nd1, input bit [5:0] nd);
        ack_mode = mode;
        @(negedge clk);
        chk("ready_pre", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_divby1 = d1;
        req_div    = d;
        expq.push_back(model_req(d1, d, mode));
        wait_result(keep, nd1, nd);
    endtask

    initial begin
        int hits;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_divby1 = 1'b0;
        req_div    = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_divby1", int'(divby1), 1);
        chk("rst_div", int'(div), 0);
        chk("rst_hold", int'(hold), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(req_ready), 1);
        hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (done || err || hold || !req_ready) hits++;
        end
        chk("idle_quiet", hits, 0);

        // div=3 with ack lagging hold by two cycles: S=8
        do_req(1'b0, 6'd3, 2, 1'b0, 1'b0, 6'd0);
        repeat (3) @(negedge clk);

        // bypass, ack immediate: S=SETTLE_MIN, div stays 3
        do_req(1'b1, 6'd3, 1, 1'b0, 1'b0, 6'd0);

        // no ack: timeout, config unchanged
        do_req(1'b0, 6'd10, 0, 1'b0, 1'b0, 6'd0);

        // next request accepted right after the abort; S=4 exactly
        do_req(1'b0, 6'd1, 1, 1'b0, 1'b0, 6'd0);

        // div=63 (S=128) with a second request held pending throughout
        do_req(1'b0, 6'd63, 1, 1'b1, 1'b0, 6'd0);
        chk("pending_valid", int'(req_valid), 1);
        expq.push_back(model_req(1'b0, 6'd0, 1));
        wait_result(1'b0, 1'b0, 6'd0);

        // reset in SETTLE discards the new config
        ack_mode = 1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_divby1 = 1'b0;
        req_div    = 6'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_div_applied", int'(div), 7);
        @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_divby1", int'(divby1), 1);
        chk("mrst_div", int'(div), 0);
        chk("mrst_hold", int'(hold), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        rst    = 1'b0;
        cur_d1 = 1'b1;
        cur_d  = 6'd0;
        hits   = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || err || busy) hits++;
        end
        chk("post_rst_quiet", hits, 0);
        chk("post_rst_divby1", int'(divby1), int'(cur_d1));
        chk("post_rst_div", int'(div), int'(cur_d));
        chk("q_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
